// File: rtl/fp_normalize_seq.sv
// fp_normalize_seq: one-bit-per-cycle post-add normaliser (in: valid/ready, sign, exp, 25b raw sum; out: valid/ready, packed result, lshift, overflow/underflow/inexact)
module fp_normalize_seq #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic [FRAC_W+1:0]       in_mant,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   out_result,
  output logic [4:0]              out_lshift,
  output logic                    out_overflow,
  output logic                    out_underflow,
  output logic                    out_inexact
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic sign_q;
  logic [EXP_W-1:0] exp_q, exp_inc, res_exp;
  logic [FRAC_W+1:0] mant_q;
  logic [FRAC_W-1:0] res_frac;
  logic [4:0] cnt_q;
  logic special, zero, carry, norm, stop, ovf, res_sign;
  always_comb begin
    special  = &exp_q;
    zero     = ~|mant_q;
    carry    = mant_q[FRAC_W+1];
    norm     = mant_q[FRAC_W];
    exp_inc  = exp_q + EXP_W'(1);
    stop     = special | zero | carry | norm | (exp_q == EXP_W'(1));
    ovf      = !special && !zero && carry && (&exp_inc);
    res_sign = sign_q && !(zero && !special);
    res_exp  = special ? '1 : zero ? '0 : carry ? exp_inc : norm ? exp_q : '0;
    res_frac = (special || !(zero || carry)) ? mant_q[FRAC_W-1:0] : (zero || ovf) ? '0 : mant_q[FRAC_W:1];
    state_n  = state == IDLE  ? (in_valid ? SHIFT : IDLE) :
               state == SHIFT ? (stop ? DONE : SHIFT) :
               (out_valid && out_ready) ? IDLE : DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
      cnt_q         <= '0;
      sign_q        <= 1'b0;
      exp_q         <= '0;
      mant_q        <= '0;
    end else begin
      state     <= state_n;
      out_valid <= state == DONE && !(out_valid && out_ready);
      if (state == IDLE && in_valid) begin
        sign_q <= in_sign;
        exp_q  <= (in_exp == '0 && in_mant != '0) ? EXP_W'(1) : in_exp;
        mant_q <= in_mant;
        cnt_q  <= '0;
      end
      if (state == SHIFT && stop) begin
        out_result    <= {res_sign, res_exp, res_frac};
        out_overflow  <= ovf;
        out_underflow <= !special && !zero && !carry && !norm;
        out_inexact   <= !special && !zero && carry && mant_q[0];
      end
      if (state == SHIFT && !stop) begin
        mant_q <= mant_q << 1;
        exp_q  <= exp_q - EXP_W'(1);
        cnt_q  <= cnt_q + 5'd1;
      end
    end
  end
  assign in_ready   = state == IDLE;
  assign out_lshift = cnt_q;
endmodule

// File: tb/tb_fp_normalize_seq.sv
// tb_fp_normalize_seq: scoreboard bench for fp_normalize_seq with directed and random operands
module tb_fp_normalize_seq;
  logic clk = 0, rst = 1, in_valid = 0, in_sign = 0, out_ready = 0;
  logic [7:0] in_exp = '0;
  logic [24:0] in_mant = '0;
  logic in_ready, out_valid, out_overflow, out_underflow, out_inexact;
  logic [31:0] out_result;
  logic [4:0] out_lshift;
  int errors = 0, checks = 0, cyc = 0, rdy_mode = 1;
  logic [31:0] last_res = '0;
  logic [4:0] last_ls = '0;
  logic [2:0] last_fl = '0;
  typedef struct {
    logic [31:0] res;
    int k;
    logic ovf, unf, inx;
    int acc;
    bit seen;
  } item_t;
  item_t q[$];

  fp_normalize_seq #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_lshift(out_lshift), .out_overflow(out_overflow),
    .out_underflow(out_underflow), .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    out_ready = rdy_mode == 0 ? 1'b0 : rdy_mode == 1 ? 1'b1 : ($urandom_range(0, 2) != 0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: find the leading one, shift as far as the exponent allows.
  function automatic item_t model(input logic s, input logic [7:0] e, input logic [24:0] m);
    item_t r;
    int we, p, need, n;
    logic [24:0] t;
    r.res = '0; r.k = 0; r.ovf = 0; r.unf = 0; r.inx = 0; r.acc = 0; r.seen = 0;
    if (e == 8'hFF) r.res = {s, 8'hFF, m[22:0]};
    else if (m == 0) r.res = '0;
    else begin
      we = (e == 0) ? 1 : int'(e);
      if (m[24]) begin
        r.inx = m[0];
        if (we + 1 == 255) begin r.res = {s, 8'hFF, 23'd0}; r.ovf = 1; end
        else r.res = {s, 8'(we + 1), m[23:1]};
      end else begin
        p = 0;
        for (int i = 0; i < 24; i++) if (m[i]) p = i;
        need = 23 - p;
        n = (need <= we - 1) ? need : we - 1;
        t = m << n;
        r.k = n;
        if (need <= we - 1) r.res = {s, 8'(we - n), t[22:0]};
        else begin r.res = {s, 8'd0, t[22:0]}; r.unf = 1; end
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    item_t it;
    if (rst) q.delete();
    else begin
      if (q.size() > 0) chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_valid", {31'd0, out_valid}, 32'd0);
        else begin
          if (!q[0].seen) begin
            chk("latency", cyc - q[0].acc, q[0].k + 2);
            q[0].seen = 1;
          end
          chk("result", out_result, q[0].res);
          chk("lshift", {27'd0, out_lshift}, q[0].k);
          chk("flags", {29'd0, out_overflow, out_underflow, out_inexact}, {29'd0, q[0].ovf, q[0].unf, q[0].inx});
          if (out_ready) begin
            last_res = out_result;
            last_ls = out_lshift;
            last_fl = {out_overflow, out_underflow, out_inexact};
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        it = model(in_sign, in_exp, in_mant);
        it.acc = cyc + 1;
        q.push_back(it);
      end
    end
  end

  task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m);
    for (int n = 0; n < 100 && !in_ready; n++) begin @(posedge clk); #1; end
    chk("send_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1; in_sign = s; in_exp = e; in_mant = m;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && q.size() != 0; n++) begin @(posedge clk); #1; end
    chk("drain", q.size(), 0);
  endtask

  task automatic dir(input logic s, input logic [7:0] e, input logic [24:0] m,
                     input logic [31:0] res, input logic [4:0] ls, input logic [2:0] fl);
    send(s, e, m);
    drain();
    chk("dir_result", last_res, res);
    chk("dir_lshift", {27'd0, last_ls}, {27'd0, ls});
    chk("dir_flags", {29'd0, last_fl}, {29'd0, fl});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel;
    logic [24:0] m;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_lshift", {27'd0, out_lshift}, 32'd0);
    chk("rst_flags", {29'd0, out_overflow, out_underflow, out_inexact}, 32'd0);
    rst = 0;
    chk("pin_norm", model(1, 8'h7F, 25'h0800000).res, 32'hBF800000);
    chk("pin_maxk", model(0, 8'h7F, 25'h0000001).k, 23);
    chk("pin_denorm", model(0, 8'h05, 25'h0000100).res, 32'h00001000);
    dir(1, 8'h7F, 25'h0800000, 32'hBF800000, 5'd0,  3'b000);
    dir(0, 8'h80, 25'h1800001, 32'h40C00000, 5'd0,  3'b001);
    dir(0, 8'h7F, 25'h0000001, 32'h34000000, 5'd23, 3'b000);
    dir(0, 8'h05, 25'h0000100, 32'h00001000, 5'd4,  3'b010);
    dir(0, 8'hFE, 25'h1000000, 32'h7F800000, 5'd0,  3'b100);
    dir(1, 8'h40, 25'h0000000, 32'h00000000, 5'd0,  3'b000);
    dir(1, 8'hFF, 25'h0ABCDEF, 32'hFFABCDEF, 5'd0,  3'b000);
    dir(0, 8'h00, 25'h0400000, 32'h00400000, 5'd0,  3'b010);
    rdy_mode = 0;
    send(0, 8'h80, 25'h1800001);
    for (int n = 0; n < 50 && !out_valid; n++) begin @(posedge clk); #1; end
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result", out_result, 32'h40C00000);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    rdy_mode = 1;
    drain();
    send(0, 8'h7F, 25'h0000001);
    repeat (5) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    dir(0, 8'h80, 25'h1800001, 32'h40C00000, 5'd0, 3'b001);
    rdy_mode = 2;
    repeat (3000) begin
      sel = $urandom_range(0, 5);
      m = 25'($urandom);
      m = m >> $urandom_range(0, 25);
      in_valid = $urandom_range(0, 1) == 1;
      in_sign = 1'($urandom);
      in_exp = sel == 0 ? 8'h00 : sel == 1 ? 8'h01 : sel == 2 ? 8'hFE : sel == 3 ? 8'hFF : 8'($urandom);
      in_mant = m;
      @(posedge clk); #1;
    end
    in_valid = 0;
    rdy_mode = 1;
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
